// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared encodings and helpers for the hazard controller
//
// Purpose: operand-forwarding select codes, FSM state encoding and the
//          forwarding priority function shared by hazard_ctrl.
// Ports:   none (package).

package hazard_ctrl_pkg;

    // EX operand source select
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Flush down-counter width; FLUSH_CYCLES is limited to 1..7
    localparam int FLUSH_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_BR_FLUSH = 2'b10
    } hz_state_t;

    // MEM wins over WB because it holds the younger value; x0 is hardwired
    // to zero and must never be forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] mem_rd,
        input logic       mem_we,
        input logic [4:0] wb_rd,
        input logic       wb_we
    );
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs))
            return FWD_MEM;
        else if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// rtl/hazard_ctrl_sat_counter.sv - saturating event counter
//
// Purpose: counts single-cycle increment pulses, holding at all-ones.
// Ports:   i_clk   clock (state changes on the falling edge)
//          i_rst   asynchronous active-high reset
//          i_inc   increment request
//          i_clear synchronous clear
//          o_count current count

module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(negedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_inc && (r_count != {WIDTH{1'b1}}))
            r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline forwarding, load-use stall and branch flush control
//
// Purpose: selects EX operand forwarding sources, detects load-use hazards,
//          sequences branch flushes and keeps stall/flush statistics.
// Ports:   CLK, RST                    clock (falling-edge state), async reset
//          idRs1, idRs2                ID source registers
//          exRs1, exRs2                EX source registers
//          exRd, exMemRead, exRegWrite EX destination / load / writeback
//          memRd, memRegWrite          MEM destination / writeback
//          wbRd, wbRegWrite            WB destination / writeback
//          branchTaken                 branch resolved taken in EX
//          fwdA, fwdB                  EX operand forwarding selects
//          pcStall, ifIdStall          hold PC and IF/ID
//          idExBubble, ifIdFlush       bubble ID/EX, clear IF/ID
//          stallCount, flushCount      saturating statistics
//          hzState                     FSM state for debug

module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       idRs1,
    input  logic [4:0]       idRs2,
    input  logic [4:0]       exRs1,
    input  logic [4:0]       exRs2,
    input  logic [4:0]       exRd,
    input  logic             exMemRead,
    input  logic             exRegWrite,
    input  logic [4:0]       memRd,
    input  logic             memRegWrite,
    input  logic [4:0]       wbRd,
    input  logic             wbRegWrite,
    input  logic             branchTaken,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic             pcStall,
    output logic             ifIdStall,
    output logic             idExBubble,
    output logic             ifIdFlush,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount,
    output logic [1:0]       hzState
);

    // Cycles spent in BR_FLUSH after the cycle the branch is taken
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    hz_state_t              r_state;
    logic [FLUSH_CNT_W-1:0] r_flush_cnt;

    logic w_lu;
    logic w_take_branch;
    logic w_stall;
    logic w_flush;

    // exRegWrite is implied by exMemRead for a load; kept for interface completeness
    logic w_unused;
    assign w_unused = exRegWrite;

    assign fwdA = fwd_sel(exRs1, memRd, memRegWrite, wbRd, wbRegWrite);
    assign fwdB = fwd_sel(exRs2, memRd, memRegWrite, wbRd, wbRegWrite);

    assign w_lu = exMemRead && (exRd != 5'd0) && ((exRd == idRs1) || (exRd == idRs2));

    // A branch taken in RUN or LU_STALL flushes; while flushing the branch
    // input belongs to a squashed instruction and is ignored.
    assign w_take_branch = branchTaken && (r_state != ST_BR_FLUSH);

    // The branch wins over a load-use hazard: the dependent instruction is
    // being flushed anyway, so stalling for it would waste a cycle.
    assign w_stall = (r_state == ST_RUN) && !branchTaken && w_lu;
    assign w_flush = w_take_branch || (r_state == ST_BR_FLUSH);

    // Control outputs are Mealy so the hazard is handled in the cycle it is
    // seen; they are forced low while reset is held.
    assign pcStall    = w_stall && !RST;
    assign ifIdStall  = w_stall && !RST;
    assign idExBubble = (w_stall || w_flush) && !RST;
    assign ifIdFlush  = w_flush && !RST;
    assign hzState    = r_state;

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN, ST_LU_STALL: begin
                    if (branchTaken) begin
                        if (FLUSH_CYCLES > 1) begin
                            r_state     <= ST_BR_FLUSH;
                            r_flush_cnt <= FLUSH_RELOAD;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end else if ((r_state == ST_RUN) && w_lu) begin
                        r_state <= ST_LU_STALL;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_BR_FLUSH: begin
                    if (r_flush_cnt <= FLUSH_CNT_W'(1)) begin
                        r_state     <= ST_RUN;
                        r_flush_cnt <= '0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_RUN;
                    r_flush_cnt <= '0;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_inc   (w_stall),
        .i_clear (1'b0),
        .o_count (stallCount)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_inc   (w_take_branch),
        .i_clear (1'b0),
        .o_count (flushCount)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard testbench for hazard_ctrl

module tb_hazard_ctrl;

    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [4:0]    idRs1 = '0, idRs2 = '0, exRs1 = '0, exRs2 = '0;
    logic [4:0]    exRd = '0, memRd = '0, wbRd = '0;
    logic          exMemRead = 1'b0, exRegWrite = 1'b0;
    logic          memRegWrite = 1'b0, wbRegWrite = 1'b0, branchTaken = 1'b0;
    logic [1:0]    fwdA, fwdB, hzState;
    logic          pcStall, ifIdStall, idExBubble, ifIdFlush;
    logic [CW-1:0] stallCount, flushCount;

    hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST),
        .idRs1(idRs1), .idRs2(idRs2), .exRs1(exRs1), .exRs2(exRs2),
        .exRd(exRd), .exMemRead(exMemRead), .exRegWrite(exRegWrite),
        .memRd(memRd), .memRegWrite(memRegWrite),
        .wbRd(wbRd), .wbRegWrite(wbRegWrite),
        .branchTaken(branchTaken),
        .fwdA(fwdA), .fwdB(fwdB),
        .pcStall(pcStall), .ifIdStall(ifIdStall),
        .idExBubble(idExBubble), .ifIdFlush(ifIdFlush),
        .stallCount(stallCount), .flushCount(flushCount),
        .hzState(hzState)
    );

    always #5 CLK = ~CLK;

    // {fwdA, fwdB, pcStall, ifIdStall, idExBubble, ifIdFlush, hzState, stallCount, flushCount}
    typedef struct {
        string       name;
        logic [17:0] vec;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic expect_out(input string name, input logic [1:0] fa, input logic [1:0] fb,
                              input logic ps, input logic is_, input logic bub, input logic fl,
                              input logic [1:0] st, input logic [3:0] sc, input logic [3:0] fc);
        exp_t e;
        e.name = name;
        e.vec  = {fa, fb, ps, is_, bub, fl, st, sc, fc};
        q.push_back(e);
    endtask

    // Inputs change just after the falling (state) edge; monitor samples on the rising edge
    task automatic next_cycle();
        @(negedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        idRs1 = '0; idRs2 = '0; exRs1 = '0; exRs2 = '0;
        exRd = '0; memRd = '0; wbRd = '0;
        exMemRead = 0; exRegWrite = 0; memRegWrite = 0; wbRegWrite = 0; branchTaken = 0;
    endtask

    task automatic set_lu(input logic on);
        exMemRead = on; exRegWrite = on; exRd = on ? 5'd3 : 5'd0; idRs2 = on ? 5'd3 : 5'd0;
    endtask

    always @(posedge CLK) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [17:0] act;
            e   = q.pop_front();
            act = {fwdA, fwdB, pcStall, ifIdStall, idExBubble, ifIdFlush, hzState, stallCount, flushCount};
            n_total++;
            if (act === e.vec)
                n_pass++;
            else
                $display("FAIL %s: got %b_%b_%b%b%b%b_%b_%0d_%0d expected %b_%b_%b%b%b%b_%b_%0d_%0d",
                         e.name, act[17:16], act[15:14], act[13], act[12], act[11], act[10],
                         act[9:8], act[7:4], act[3:0],
                         e.vec[17:16], e.vec[15:14], e.vec[13], e.vec[12], e.vec[11], e.vec[10],
                         e.vec[9:8], e.vec[7:4], e.vec[3:0]);
        end
    end

    initial begin
        int sc;
        // Forwarding stays live during reset; everything else is zero
        next_cycle();
        RST = 1; exRs1 = 5; memRd = 5; memRegWrite = 1; branchTaken = 1; set_lu(1);
        expect_out("reset_state", 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
        next_cycle();
        RST = 0; clear_inputs();

        // Forwarding priority and x0
        exRs1 = 5; memRd = 5; wbRd = 5; memRegWrite = 1; wbRegWrite = 1;
        expect_out("fwd_mem", 2'b01, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
        next_cycle();
        memRegWrite = 0;
        expect_out("fwd_wb", 2'b10, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
        next_cycle();
        memRd = 0; wbRd = 0; memRegWrite = 1;
        expect_out("fwd_rd0", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
        next_cycle();
        exRs1 = 0; exRs2 = 0;
        expect_out("fwd_x0", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
        next_cycle();
        exRs1 = 9; exRs2 = 9; memRd = 9; wbRd = 9;
        expect_out("fwd_ab_mem", 2'b01, 2'b01, 0, 0, 0, 0, 2'b00, 0, 0);
        next_cycle();
        exRs1 = 4; memRd = 4; wbRd = 9; exRs2 = 9;
        expect_out("fwd_a_mem_b_wb", 2'b01, 2'b10, 0, 0, 0, 0, 2'b00, 0, 0);
        next_cycle();
        clear_inputs();

        // Single load-use stall
        set_lu(1);
        expect_out("lu_hit", 2'b00, 2'b00, 1, 1, 1, 0, 2'b00, 0, 0);
        next_cycle();
        expect_out("lu_stall_state", 2'b00, 2'b00, 0, 0, 0, 0, 2'b01, 1, 0);
        next_cycle();
        set_lu(0);
        expect_out("lu_back_run", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 1, 0);
        next_cycle();
        exMemRead = 1; exRd = 0; idRs1 = 0;
        expect_out("lu_x0", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 1, 0);
        next_cycle();
        clear_inputs();

        // Branch flush lasting 3 cycles; LU ignored while flushing
        branchTaken = 1;
        expect_out("br_c1", 2'b00, 2'b00, 0, 0, 1, 1, 2'b00, 1, 0);
        next_cycle();
        branchTaken = 0; set_lu(1);
        expect_out("br_c2", 2'b00, 2'b00, 0, 0, 1, 1, 2'b10, 1, 1);
        next_cycle();
        branchTaken = 1;
        expect_out("br_c3", 2'b00, 2'b00, 0, 0, 1, 1, 2'b10, 1, 1);
        next_cycle();
        clear_inputs();
        expect_out("br_done", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 1, 1);
        next_cycle();

        // Branch and load-use together: flush only
        branchTaken = 1; set_lu(1);
        expect_out("br_lu_same", 2'b00, 2'b00, 0, 0, 1, 1, 2'b00, 1, 1);
        next_cycle();
        clear_inputs();
        expect_out("br_lu_f2", 2'b00, 2'b00, 0, 0, 1, 1, 2'b10, 1, 2);
        next_cycle();
        expect_out("br_lu_f3", 2'b00, 2'b00, 0, 0, 1, 1, 2'b10, 1, 2);
        next_cycle();
        expect_out("br_lu_done", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 1, 2);
        next_cycle();

        // Branch taken while in LU_STALL
        set_lu(1);
        expect_out("lus_hit", 2'b00, 2'b00, 1, 1, 1, 0, 2'b00, 1, 2);
        next_cycle();
        set_lu(0); branchTaken = 1;
        expect_out("lus_branch", 2'b00, 2'b00, 0, 0, 1, 1, 2'b01, 2, 2);
        next_cycle();
        branchTaken = 0;
        expect_out("lus_f2", 2'b00, 2'b00, 0, 0, 1, 1, 2'b10, 2, 3);
        next_cycle();
        expect_out("lus_f3", 2'b00, 2'b00, 0, 0, 1, 1, 2'b10, 2, 3);
        next_cycle();
        expect_out("lus_done", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 2, 3);
        next_cycle();

        // Reset in the second BR_FLUSH cycle aborts cleanly
        branchTaken = 1;
        expect_out("rf_take", 2'b00, 2'b00, 0, 0, 1, 1, 2'b00, 2, 3);
        next_cycle();
        branchTaken = 0;
        expect_out("rf_f1", 2'b00, 2'b00, 0, 0, 1, 1, 2'b10, 2, 4);
        next_cycle();
        RST = 1;
        expect_out("rf_in_reset", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
        next_cycle();
        RST = 0;
        expect_out("rf_post1", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
        next_cycle();
        expect_out("rf_post2", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0);
        next_cycle();

        // 20 load-use events on a 4-bit counter saturate at 15
        for (int k = 0; k < 20; k++) begin
            sc = (k > 15) ? 15 : k;
            set_lu(1);
            expect_out($sformatf("sat_hit%0d", k), 2'b00, 2'b00, 1, 1, 1, 0, 2'b00, 4'(sc), 0);
            next_cycle();
            set_lu(0);
            sc = (k + 1 > 15) ? 15 : k + 1;
            expect_out($sformatf("sat_stall%0d", k), 2'b00, 2'b00, 0, 0, 0, 0, 2'b01, 4'(sc), 0);
            next_cycle();
        end
        expect_out("sat_hold", 2'b00, 2'b00, 0, 0, 0, 0, 2'b00, 15, 0);

        for (int i = 0; i < 10 && q.size() != 0; i++)
            @(posedge CLK);
        #2;
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending entries expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
